// File: rtl/vx_cache_mem_qos_arb_pkg.sv
// Shared types and helpers for the cache-cluster memory QoS arbiter.
package vx_cache_mem_qos_arb_pkg;

    // Width of the source-index field appended to memory tags (never below 1).
    function automatic int qos_sel_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Cluster-default memory request geometry.
    localparam int MEM_ADDR_WIDTH = 26;
    localparam int MEM_LINE_SIZE  = 64;
    localparam int MEM_TAG_WIDTH  = 8 + qos_sel_bits(4);

    // Memory request as seen on the shared bus of the cluster.
    typedef struct packed {
        logic                         rw;
        logic [MEM_ADDR_WIDTH-1:0]    addr;
        logic [MEM_LINE_SIZE*8-1:0]   data;
        logic [MEM_LINE_SIZE-1:0]     byteen;
        logic [MEM_TAG_WIDTH-1:0]     tag;
    } mem_req_t;

endpackage

// File: rtl/vx_cache_mem_qos_arb_rr_picker.sv
// Round-robin picker: first set bit of cand at or above ptr, wrapping.
module vx_qos_rr_picker
    import vx_cache_mem_qos_arb_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int SEL_BITS   = qos_sel_bits(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] cand,
    input  logic [SEL_BITS-1:0]   ptr,
    output logic [NUM_INPUTS-1:0] grant,
    output logic [SEL_BITS-1:0]   grant_idx,
    output logic                  grant_any
);

    // Scan NUM_INPUTS positions starting at ptr; the first hit wins.
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            idx = (int'(ptr) + k) % NUM_INPUTS;
            if (!grant_any && cand[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = SEL_BITS'(idx);
            end
        end
    end

endmodule

// File: rtl/vx_cache_mem_qos_arb.sv
// N-to-1 memory arbiter with read credits, weighted round-robin bursts,
// optional writeback-first priority and a registered request stage.
// Read responses return to their source via the tag LSBs.
module vx_cache_mem_qos_arb
    import vx_cache_mem_qos_arb_pkg::*;
#(
    parameter int NUM_INPUTS  = 4,
    parameter int ADDR_WIDTH  = 26,
    parameter int LINE_SIZE   = 64,
    parameter int TAG_WIDTH   = 8,
    parameter int MAX_PENDING = 4,
    parameter int WEIGHT      = 2,
    parameter int WB_PRIORITY = 1,
    // Derived: source-index width, leave at default.
    parameter int SEL_BITS    = qos_sel_bits(NUM_INPUTS)
) (
    input  logic                                  clk,
    input  logic                                  reset,

    input  logic [NUM_INPUTS-1:0]                 in_req_valid,
    input  logic [NUM_INPUTS-1:0]                 in_req_rw,
    input  logic [NUM_INPUTS*ADDR_WIDTH-1:0]      in_req_addr,
    input  logic [NUM_INPUTS*LINE_SIZE*8-1:0]     in_req_data,
    input  logic [NUM_INPUTS*LINE_SIZE-1:0]       in_req_byteen,
    input  logic [NUM_INPUTS*TAG_WIDTH-1:0]       in_req_tag,
    output logic [NUM_INPUTS-1:0]                 in_req_ready,

    output logic                                  out_req_valid,
    output logic                                  out_req_rw,
    output logic [ADDR_WIDTH-1:0]                 out_req_addr,
    output logic [LINE_SIZE*8-1:0]                out_req_data,
    output logic [LINE_SIZE-1:0]                  out_req_byteen,
    output logic [TAG_WIDTH+SEL_BITS-1:0]         out_req_tag,
    input  logic                                  out_req_ready,

    input  logic                                  out_rsp_valid,
    input  logic [LINE_SIZE*8-1:0]                out_rsp_data,
    input  logic [TAG_WIDTH+SEL_BITS-1:0]         out_rsp_tag,
    output logic                                  out_rsp_ready,

    output logic [NUM_INPUTS-1:0]                 in_rsp_valid,
    output logic [NUM_INPUTS*LINE_SIZE*8-1:0]     in_rsp_data,
    output logic [NUM_INPUTS*TAG_WIDTH-1:0]       in_rsp_tag,
    input  logic [NUM_INPUTS-1:0]                 in_rsp_ready
);

    localparam int LINE_W  = LINE_SIZE * 8;
    localparam int OTAG_W  = TAG_WIDTH + SEL_BITS;
    localparam int CNT_W   = $clog2(MAX_PENDING + 1);
    localparam int BURST_W = (WEIGHT > 1) ? $clog2(WEIGHT) : 1;

    typedef struct packed {
        logic                  rw;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LINE_W-1:0]     data;
        logic [LINE_SIZE-1:0]  byteen;
        logic [OTAG_W-1:0]     tag;
    } req_t;

    // Saturating credit arithmetic; increments cannot overflow because
    // eligibility already blocks reads at MAX_PENDING.
    function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] c);
        return (c == CNT_W'(MAX_PENDING)) ? c : c + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_dec_sat(input logic [CNT_W-1:0] c);
        return (c == '0) ? c : c - 1'b1;
    endfunction

    function automatic logic [SEL_BITS-1:0] next_ptr(input logic [SEL_BITS-1:0] g);
        return SEL_BITS'((int'(g) + 1) % NUM_INPUTS);
    endfunction

    logic [CNT_W-1:0]      pending [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] elig;
    logic [NUM_INPUTS-1:0] wr_elig;
    logic [NUM_INPUTS-1:0] cand;
    logic [NUM_INPUTS-1:0] grant;
    logic [SEL_BITS-1:0]   grant_idx;
    logic                  grant_any;
    logic                  stage_free;
    logic                  fire;

    logic [SEL_BITS-1:0]   rr_ptr, rr_ptr_nxt;
    logic [SEL_BITS-1:0]   last_idx, last_idx_nxt;
    logic [BURST_W-1:0]    burst, burst_nxt;

    logic [NUM_INPUTS-1:0] rd_inc;
    logic [NUM_INPUTS-1:0] rsp_dec;
    logic [SEL_BITS-1:0]   rsp_sel;
    logic                  sel_ok;
    logic                  rsp_fire;

    req_t                  req_p0;
    req_t                  req_p1;
    logic                  vld_p1;

    // ---- p0: eligibility, priority filter and grant ----

    // Reads need a free credit; writebacks are always eligible.
    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            elig[i] = in_req_valid[i] & (in_req_rw[i] | (pending[i] < CNT_W'(MAX_PENDING)));
        end
        wr_elig = elig & in_req_rw;
        cand    = ((WB_PRIORITY != 0) && (|wr_elig)) ? wr_elig : elig;
    end

    vx_qos_rr_picker #(
        .NUM_INPUTS (NUM_INPUTS),
        .SEL_BITS   (SEL_BITS)
    ) picker (
        .cand      (cand),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign stage_free   = ~vld_p1 | out_req_ready;
    assign fire         = grant_any & stage_free;
    assign in_req_ready = grant & {NUM_INPUTS{stage_free}};

    // Select the granted input's payload and append its source index.
    always_comb begin
        req_p0 = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant[i]) begin
                req_p0.rw     = in_req_rw[i];
                req_p0.addr   = in_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                req_p0.data   = in_req_data[i*LINE_W +: LINE_W];
                req_p0.byteen = in_req_byteen[i*LINE_SIZE +: LINE_SIZE];
                req_p0.tag    = {in_req_tag[i*TAG_WIDTH +: TAG_WIDTH], SEL_BITS'(i)};
            end
        end
    end

    // Weighted round-robin: stay on an input for up to WEIGHT grants in a row.
    always_comb begin
        rr_ptr_nxt   = rr_ptr;
        burst_nxt    = burst;
        last_idx_nxt = last_idx;
        if (fire) begin
            last_idx_nxt = grant_idx;
            if ((grant_idx == last_idx) && ((int'(burst) + 1) < WEIGHT)) begin
                burst_nxt  = burst + 1'b1;
                rr_ptr_nxt = grant_idx;
            end else if ((grant_idx == last_idx) || (WEIGHT == 1)) begin
                burst_nxt  = '0;
                rr_ptr_nxt = next_ptr(grant_idx);
            end else begin
                burst_nxt  = BURST_W'(1);
                rr_ptr_nxt = grant_idx;
            end
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr   <= '0;
            burst    <= '0;
            last_idx <= '0;
        end else begin
            rr_ptr   <= rr_ptr_nxt;
            burst    <= burst_nxt;
            last_idx <= last_idx_nxt;
        end
    end

    // ---- p1: registered request stage ----

    // Valid is set by a fire and dropped only when the bus takes it with nothing new behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else if (fire) begin
            vld_p1 <= 1'b1;
        end else if (out_req_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    // Payload loads only on fire, so it holds steady across a stall.
    always_ff @(posedge clk) begin
        if (fire) begin
            req_p1 <= req_p0;
        end
    end

    assign out_req_valid  = vld_p1;
    assign out_req_rw     = req_p1.rw;
    assign out_req_addr   = req_p1.addr;
    assign out_req_data   = req_p1.data;
    assign out_req_byteen = req_p1.byteen;
    assign out_req_tag    = req_p1.tag;

    // ---- response path (combinational) ----

    assign rsp_sel  = out_rsp_tag[SEL_BITS-1:0];
    assign sel_ok   = int'(rsp_sel) < NUM_INPUTS;
    assign rsp_fire = out_rsp_valid & out_rsp_ready;

    // Steer valid to the tagged input and take its ready; bad indices are sunk.
    always_comb begin
        in_rsp_valid  = '0;
        out_rsp_ready = 1'b1;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (rsp_sel == SEL_BITS'(i)) begin
                in_rsp_valid[i] = out_rsp_valid;
                out_rsp_ready   = in_rsp_ready[i];
            end
        end
    end

    assign in_rsp_data = {NUM_INPUTS{out_rsp_data}};
    assign in_rsp_tag  = {NUM_INPUTS{out_rsp_tag[SEL_BITS +: TAG_WIDTH]}};

    // Per-input credit events for this cycle.
    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            rd_inc[i]  = fire & grant[i] & ~in_req_rw[i];
            rsp_dec[i] = rsp_fire & sel_ok & (rsp_sel == SEL_BITS'(i));
        end
    end

    // Outstanding-read counters; a read and a response on the same input cancel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                pending[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (rd_inc[i] && !rsp_dec[i]) begin
                    pending[i] <= cnt_inc_sat(pending[i]);
                end else if (rsp_dec[i] && !rd_inc[i]) begin
                    pending[i] <= cnt_dec_sat(pending[i]);
                end
            end
        end
    end

    // A response for an input with no reads outstanding is a protocol error.
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_chk
        a_no_underflow: assert property (@(posedge clk) disable iff (reset)
            !(rsp_dec[i] && (pending[i] == '0)));
    end

    // Responses must carry a source index that names a real input.
    a_sel_range: assert property (@(posedge clk) disable iff (reset)
        !(out_rsp_valid && !sel_ok));

endmodule

// File: tb/tb_vx_cache_mem_qos_arb.sv
// Bench for vx_cache_mem_qos_arb: vector table, directed corner sequences and
// randomized traffic against a transaction-level model.
module tb_vx_cache_mem_qos_arb;

    localparam int N = 4, AW = 26, LS = 64, LW = 512, TW = 8, OTW = 10;
    localparam int MAXP = 4, WEIGHT = 2;

    logic clk = 1'b0;
    logic reset;

    logic [N-1:0]      in_req_valid, in_req_rw, in_req_ready;
    logic [N*AW-1:0]   in_req_addr;
    logic [N*LW-1:0]   in_req_data;
    logic [N*LS-1:0]   in_req_byteen;
    logic [N*TW-1:0]   in_req_tag;
    logic              out_req_valid, out_req_rw, out_req_ready;
    logic [AW-1:0]     out_req_addr;
    logic [LW-1:0]     out_req_data;
    logic [LS-1:0]     out_req_byteen;
    logic [OTW-1:0]    out_req_tag;
    logic              out_rsp_valid, out_rsp_ready;
    logic [LW-1:0]     out_rsp_data;
    logic [OTW-1:0]    out_rsp_tag;
    logic [N-1:0]      in_rsp_valid, in_rsp_ready;
    logic [N*LW-1:0]   in_rsp_data;
    logic [N*TW-1:0]   in_rsp_tag;

    // Second instance: reads and writes share one round-robin (no writeback priority).
    logic [N-1:0]      p_valid, p_rw, p_ready, p_rsp_valid;
    logic [N*AW-1:0]   p_addr;
    logic [N*32-1:0]   p_data, p_rsp_data;
    logic [N*4-1:0]    p_be;
    logic [N*TW-1:0]   p_tag, p_rsp_tag;
    logic              p_oreq_valid, p_oreq_rw, p_orsp_ready;
    logic [AW-1:0]     p_oreq_addr;
    logic [31:0]       p_oreq_data;
    logic [3:0]        p_oreq_be;
    logic [OTW-1:0]    p_oreq_tag;

    vx_cache_mem_qos_arb dut (
        .clk(clk), .reset(reset),
        .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_addr(in_req_addr),
        .in_req_data(in_req_data), .in_req_byteen(in_req_byteen), .in_req_tag(in_req_tag),
        .in_req_ready(in_req_ready),
        .out_req_valid(out_req_valid), .out_req_rw(out_req_rw), .out_req_addr(out_req_addr),
        .out_req_data(out_req_data), .out_req_byteen(out_req_byteen), .out_req_tag(out_req_tag),
        .out_req_ready(out_req_ready),
        .out_rsp_valid(out_rsp_valid), .out_rsp_data(out_rsp_data), .out_rsp_tag(out_rsp_tag),
        .out_rsp_ready(out_rsp_ready),
        .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data), .in_rsp_tag(in_rsp_tag),
        .in_rsp_ready(in_rsp_ready)
    );

    vx_cache_mem_qos_arb #(.LINE_SIZE(4), .WB_PRIORITY(0)) dut_nowb (
        .clk(clk), .reset(reset),
        .in_req_valid(p_valid), .in_req_rw(p_rw), .in_req_addr(p_addr),
        .in_req_data(p_data), .in_req_byteen(p_be), .in_req_tag(p_tag),
        .in_req_ready(p_ready),
        .out_req_valid(p_oreq_valid), .out_req_rw(p_oreq_rw), .out_req_addr(p_oreq_addr),
        .out_req_data(p_oreq_data), .out_req_byteen(p_oreq_be), .out_req_tag(p_oreq_tag),
        .out_req_ready(1'b1),
        .out_rsp_valid(1'b0), .out_rsp_data(32'h0), .out_rsp_tag(10'h0),
        .out_rsp_ready(p_orsp_ready),
        .in_rsp_valid(p_rsp_valid), .in_rsp_data(p_rsp_data), .in_rsp_tag(p_rsp_tag),
        .in_rsp_ready(4'hF)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state: credits, round-robin position and the output stage.
    int          m_ptr, m_burst, m_last;
    int          m_pend [N];
    bit          m_vld;
    logic        m_rw;
    logic [AW-1:0]  m_addr;
    logic [LW-1:0]  m_data;
    logic [LS-1:0]  m_be;
    logic [OTW-1:0] m_tag;
    logic [N-1:0]   s_ready;

    task automatic model_reset();
        m_ptr = 0; m_burst = 0; m_last = 0; m_vld = 0;
        for (int i = 0; i < N; i++) m_pend[i] = 0;
    endtask

    // Winner among current requests, or -1.
    function automatic int model_pick();
        bit [N-1:0] elig, cand;
        for (int i = 0; i < N; i++)
            elig[i] = in_req_valid[i] && (in_req_rw[i] || m_pend[i] < MAXP);
        cand = ((elig & in_req_rw) != 0) ? (elig & in_req_rw) : elig;
        for (int k = 0; k < N; k++)
            if (cand[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    // Check every output against the model for the current inputs, then advance one cycle.
    task automatic step();
        int g, sel;
        bit fire;
        #1;
        g    = model_pick();
        fire = (g >= 0) && (!m_vld || out_req_ready);
        sel  = int'(out_rsp_tag[1:0]);
        s_ready = in_req_ready;
        chk("in_req_ready", in_req_ready, fire ? (LW'(1) << g) : '0);
        chk("out_req_valid", out_req_valid, m_vld);
        if (m_vld) begin
            chk("out_req_rw", out_req_rw, m_rw);
            chk("out_req_addr", out_req_addr, m_addr);
            chk("out_req_data", out_req_data, m_data);
            chk("out_req_byteen", out_req_byteen, m_be);
            chk("out_req_tag", out_req_tag, m_tag);
        end
        chk("in_rsp_valid", in_rsp_valid, out_rsp_valid ? (LW'(1) << sel) : '0);
        chk("out_rsp_ready", out_rsp_ready, in_rsp_ready[sel]);
        if (out_rsp_valid) begin
            chk("in_rsp_tag", in_rsp_tag[sel*TW +: TW], out_rsp_tag[OTW-1:2]);
            chk("in_rsp_data", in_rsp_data[sel*LW +: LW], out_rsp_data);
        end
        if (fire) begin
            m_vld  = 1;
            m_rw   = in_req_rw[g];
            m_addr = in_req_addr[g*AW +: AW];
            m_data = in_req_data[g*LW +: LW];
            m_be   = in_req_byteen[g*LS +: LS];
            m_tag  = {in_req_tag[g*TW +: TW], 2'(g)};
            if (!in_req_rw[g]) m_pend[g]++;
            if (g == m_last && m_burst + 1 < WEIGHT) begin
                m_burst++; m_ptr = g;
            end else if (g == m_last || WEIGHT == 1) begin
                m_burst = 0; m_ptr = (g + 1) % N;
            end else begin
                m_burst = 1; m_ptr = g;
            end
            m_last = g;
        end else if (out_req_ready) begin
            m_vld = 0;
        end
        if (out_rsp_valid && in_rsp_ready[sel] && m_pend[sel] > 0) m_pend[sel]--;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_req_valid = '0; in_req_rw = '0; out_req_ready = 1'b1;
        out_rsp_valid = 1'b0; out_rsp_tag = '0; out_rsp_data = '0; in_rsp_ready = '1;
        p_valid = '0; p_rw = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic set_lane(input int i, input logic [AW-1:0] a, input logic [TW-1:0] t);
        in_req_addr[i*AW +: AW]   = a;
        in_req_tag[i*TW +: TW]    = t;
        in_req_data[i*LW +: LW]   = {16{6'(i), a}};
        in_req_byteen[i*LS +: LS] = {8{t}};
    endtask

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] rw;
        logic         ordy;
        logic [N-1:0] exp_rdy;
    } vec_t;

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        vec_t vt[13];
        logic [AW-1:0] a1;

        vt[0]  = '{4'hF, 4'h0, 1'b1, 4'b0001};
        vt[1]  = '{4'hF, 4'h0, 1'b1, 4'b0001};
        vt[2]  = '{4'hF, 4'h0, 1'b1, 4'b0010};
        vt[3]  = '{4'hF, 4'h0, 1'b1, 4'b0010};
        vt[4]  = '{4'hF, 4'h0, 1'b1, 4'b0100};
        vt[5]  = '{4'hF, 4'h0, 1'b1, 4'b0100};
        vt[6]  = '{4'hF, 4'h0, 1'b1, 4'b1000};
        vt[7]  = '{4'hF, 4'h0, 1'b1, 4'b1000};
        vt[8]  = '{4'hF, 4'h0, 1'b1, 4'b0001};
        vt[9]  = '{4'h5, 4'h4, 1'b1, 4'b0100};   // writeback beats the older read
        vt[10] = '{4'h1, 4'h0, 1'b1, 4'b0001};   // input 0 now holds 4 credits
        vt[11] = '{4'hF, 4'h0, 1'b0, 4'b0000};   // stage full and stalled
        vt[12] = '{4'hF, 4'h0, 1'b1, 4'b0010};   // input 0 out of credit, 1 next

        idle_inputs();
        p_addr = '0; p_data = '0; p_be = '0; p_tag = '0;
        for (int i = 0; i < N; i++) set_lane(i, AW'(32'h100 + i), TW'(8'h10 + i));
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_out_req_valid", out_req_valid, 1'b0);
        chk("reset_in_req_ready", in_req_ready, 4'b0000);
        reset = 1'b0;
        model_reset();
        @(negedge clk);

        // Vector table: weighted round-robin, priority, stall and credit limit.
        for (int v = 0; v < 13; v++) begin
            in_req_valid = vt[v].valid; in_req_rw = vt[v].rw; out_req_ready = vt[v].ordy;
            step();
            chk($sformatf("vec%0d_grant", v), s_ready, vt[v].exp_rdy);
        end

        // Credit limit on input 1, released by one response.
        do_reset();
        in_req_valid = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("credit_rd%0d", k), s_ready, (k < 4) ? 4'b0010 : 4'b0000);
        end
        out_rsp_valid = 1'b1; out_rsp_tag = {8'h11, 2'd1};
        step();
        chk("credit_rsp_cycle", s_ready, 4'b0000);
        out_rsp_valid = 1'b0;
        step();
        chk("credit_after_rsp", s_ready, 4'b0010);

        // Output stall: payload held, no input accepted; ready reloads same cycle.
        do_reset();
        a1 = 26'h2A_5A5A;
        set_lane(0, a1, 8'h33);
        in_req_valid = 4'b0001; out_req_ready = 1'b0;
        step();
        chk("stall_first_fire", s_ready, 4'b0001);
        set_lane(0, 26'h15_0F0F, 8'h44);
        in_req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_ready", s_ready, 4'b0000);
            chk("stall_addr", out_req_addr, a1);
            chk("stall_tag", out_req_tag, {8'h33, 2'd0});
            chk("stall_valid", out_req_valid, 1'b1);
        end
        out_req_ready = 1'b1;
        step();
        chk("stall_release_grant", s_ready, 4'b0001);
        chk("stall_release_addr", out_req_addr, 26'h15_0F0F);

        // Response routing with a back-pressuring destination.
        do_reset();
        in_req_valid = 4'b1000;
        step();
        in_req_valid = 4'b0000;
        out_rsp_valid = 1'b1; out_rsp_tag = {8'h5A, 2'd3}; out_rsp_data = {16{32'hC0DE_0003}};
        in_rsp_ready = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rsp_valid_vec", in_rsp_valid, 4'b1000);
            chk("rsp_tag_lane3", in_rsp_tag[31:24], 8'h5A);
            chk("rsp_ready_low", out_rsp_ready, 1'b0);
        end
        in_rsp_ready = 4'hF;
        #1;
        chk("rsp_ready_high", out_rsp_ready, 1'b1);
        step();
        out_rsp_valid = 1'b0;

        // Asynchronous reset during a stall clears the stage and the credits.
        do_reset();
        in_req_valid = 4'b0001;
        step();
        step();
        in_req_valid = 4'b0000; out_req_ready = 1'b0;
        step();
        chk("pre_reset_valid", out_req_valid, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset_valid", out_req_valid, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        out_req_ready = 1'b1;
        in_req_valid = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("post_reset_rd%0d", k), s_ready, (k < 4) ? 4'b0001 : 4'b0000);
        end

        // No writeback priority: pointer order decides, then the burst moves on.
        do_reset();
        p_valid = 4'b0101; p_rw = 4'b0100;
        #1; chk("nowb_grant0", p_ready, 4'b0001); step();
        #1; chk("nowb_grant1", p_ready, 4'b0001); step();
        #1; chk("nowb_grant2", p_ready, 4'b0100); step();
        p_valid = '0;

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            int sel;
            in_req_valid  = 4'($urandom);
            in_req_rw     = 4'($urandom & $urandom);
            out_req_ready = ($urandom_range(3) != 0);
            for (int w = 0; w < N*LW/32; w++) in_req_data[w*32 +: 32] = $urandom;
            for (int i = 0; i < N; i++) begin
                in_req_addr[i*AW +: AW]   = AW'($urandom);
                in_req_tag[i*TW +: TW]    = TW'($urandom);
                in_req_byteen[i*LS +: LS] = {$urandom, $urandom};
            end
            sel = $urandom_range(N-1);
            out_rsp_valid = (m_pend[sel] > 0) && $urandom_range(1);
            out_rsp_tag   = {8'($urandom), 2'(sel)};
            for (int w = 0; w < LW/32; w++) out_rsp_data[w*32 +: 32] = $urandom;
            in_rsp_ready  = 4'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_cache_mem_qos_arb.md
Name: vx_cache_mem_qos_arb

Overview:
- N-to-1 memory-side arbiter between per-unit cache memory ports and the shared memory bus of a cache cluster.
- Successor to the plain round-robin memory arbiter. Adds:
  - per-input outstanding-read credit limits
  - weighted round-robin bursts
  - optional writeback-first priority
  - a registered request stage
- Read responses are routed back to their input by source-index bits carried in the memory tag.

Parameters:
- NUM_INPUTS, 4, number of cache memory ports (>=1)
- ADDR_WIDTH, 26, line-address width
- LINE_SIZE, 64, bytes per request/response data beat
- TAG_WIDTH, 8, input request tag width
- MAX_PENDING, 4, max outstanding reads per input (>=1)
- WEIGHT, 2, max consecutive grants to one input before the pointer advances (>=1)
- WB_PRIORITY, 1, 1 = eligible writes win over reads
- SEL_BITS (derived), max(1, clog2(NUM_INPUTS)), source-index width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- in_req_valid  in  NUM_INPUTS  per-input request valid
- in_req_rw  in  NUM_INPUTS  1 = write (writeback), 0 = read
- in_req_addr  in  NUM_INPUTS*ADDR_WIDTH  line address
- in_req_data  in  NUM_INPUTS*LINE_SIZE*8  write data
- in_req_byteen  in  NUM_INPUTS*LINE_SIZE  byte enables
- in_req_tag  in  NUM_INPUTS*TAG_WIDTH  request tag
- in_req_ready  out  NUM_INPUTS  per-input accept
- out_req_valid  out  1  memory request valid
- out_req_rw  out  1  write flag
- out_req_addr  out  ADDR_WIDTH  address
- out_req_data  out  LINE_SIZE*8  data
- out_req_byteen  out  LINE_SIZE  byte enables
- out_req_tag  out  TAG_WIDTH+SEL_BITS  {in_tag, sel}, sel in LSBs
- out_req_ready  in  1  memory accept
- out_rsp_valid  in  1  memory read response valid
- out_rsp_data  in  LINE_SIZE*8  response data
- out_rsp_tag  in  TAG_WIDTH+SEL_BITS  response tag
- out_rsp_ready  out  1  response accept
- in_rsp_valid  out  NUM_INPUTS  per-input response valid
- in_rsp_data  out  NUM_INPUTS*LINE_SIZE*8  response data (broadcast)
- in_rsp_tag  out  NUM_INPUTS*TAG_WIDTH  stripped tag (broadcast)
- in_rsp_ready  in  NUM_INPUTS  per-input response accept

Behaviour:
- Reset (async, immediate):
  - out_req_valid=0
  - all pending counters=0
  - rr pointer=0
  - burst count=0
  - register payload don't-care
- Eligibility: elig[i] = in_req_valid[i] & (in_req_rw[i] | pending[i] < MAX_PENDING). Writes never consume credit.
- Priority filter: if WB_PRIORITY=1 and any eligible write exists, cand = elig & rw; else cand = elig.
- Grant: first set bit of cand searching from the rr pointer upward with wrap. One-hot; zero if cand=0.
- Handshake:
  - stage_free = ~out_req_valid | out_req_ready.
  - in_req_ready[i] = grant[i] & stage_free.
  - Fire loads the output register next cycle; fire-to-out_req_valid latency is 1.
  - Back-to-back throughput is 1 request/cycle.
  - out_req_valid deasserts only when out_req_ready=1 and nothing fires.
  - Register contents are held stable while valid & ~ready.
- Burst/pointer, on each fire to input g:
  - if g equals the last granted input and burst+1 < WEIGHT: burst++, pointer=g;
  - else burst=0 (if WEIGHT=1 or the burst is exhausted, pointer=(g+1) mod N; else pointer=g and burst=1 for a new input).
  - No fire: pointer and burst hold.
- Pending counters (width clog2(MAX_PENDING+1)):
  - +1 on a read fire for input i.
  - -1 on response fire (out_rsp_valid & out_rsp_ready) with sel=i.
  - Both in the same cycle: unchanged.
  - Decrement at 0 saturates at 0; assertion fires in simulation.
- Response path (combinational, zero latency):
  - sel = out_rsp_tag[SEL_BITS-1:0].
  - in_rsp_valid[sel] = out_rsp_valid.
  - out_rsp_ready = in_rsp_ready[sel].
  - in_rsp_tag = out_rsp_tag >> SEL_BITS.
  - sel >= NUM_INPUTS: response dropped with out_rsp_ready=1; assertion fires.
- NUM_INPUTS=1: same registered stage; sel field is 1 bit, constant 0.

Decomposition:
- Package VX_gpu_pkg gains QOS_SEL_BITS(n) macro/function and a mem_req_t packed struct {rw, addr, data, byteen, tag}, shared with the cluster.
- One sub-module, vx_qos_rr_picker: cand vector + pointer -> one-hot grant + index. Pure combinational, reused by other arbiters.
- Counters and the register stay in the top module.

Test Plan:
- N=4, all inputs read-valid, out_req_ready=1, WEIGHT=2: grant sequence is 0,0,1,1,2,2,3,3,0.
- Input 1 issues 4 reads with no responses, MAX_PENDING=4: pending[1]=4 and its 5th read is not granted. One response with tag sel=1 → the 5th read is granted the following cycle.
- WB_PRIORITY=1, input 0 reads and input 2 writes concurrently: input 2 is granted first. WB_PRIORITY=0 with pointer=0: input 0 is granted first.
- out_req_ready held low 5 cycles with a loaded request: out_req_* stable and all in_req_ready=0. Ready rises → the next grant is loaded the same cycle.
- Response with tag {0x5A, sel=3} and in_rsp_ready[3]=0: in_rsp_valid=4'b1000, in_rsp_tag=0x5A, out_rsp_ready=0 until ready rises.
- Reset asserted mid-stall with out_req_valid=1 and pending[0]=2: outputs go to 0 asynchronously. After release, a stray response for sel=0 leaves pending[0]=0 and the assertion flags it.
